// File: rtl/apb_master_bridge.sv
// Single-outstanding APB4 requester: valid/ready command in, one APB transfer out, valid/ready response back.
// Latency: accept -> SETUP -> ACCESS (+wait states, bounded by TIMEOUT_CYCLES) -> RESP; req_ready only in IDLE, RESP holds until rsp_ready.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_write,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_slverr,
    output logic                    rsp_timeout,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic                    PREADY,
    input  logic                    PSLVERR,
    input  logic [DATA_WIDTH-1:0]   PRDATA
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [SW-1:0]         pstrb_q, pstrb_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  slverr_q, slverr_d;
    logic                  timeout_q, timeout_d;
    logic                  timeout_hit;

    // PREADY=1 on the last allowed edge takes priority over the abort.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && !PREADY && (cnt_q == CNT_LAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (PREADY || timeout_hit) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        PSEL      = (state_q == SETUP) || (state_q == ACCESS);
        PENABLE   = (state_q == ACCESS);
    end

    always_comb begin
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        slverr_d  = slverr_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_write ? req_wdata : '0;
                    pstrb_d  = req_write ? req_strb : '0;
                    cnt_d    = '0;
                end
            end
            ACCESS: begin
                if (PREADY) begin
                    rdata_d   = pwrite_q ? '0 : PRDATA;
                    slverr_d  = PSLVERR;
                    timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    rdata_d   = '0;
                    slverr_d  = 1'b1;
                    timeout_d = 1'b1;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            slverr_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            slverr_q  <= slverr_d;
            timeout_q <= timeout_d;
        end
    end

    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_slverr  = slverr_q;
    assign rsp_timeout = timeout_q;

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Upstream APB requester for the dual-port memory subsystem: converts a simple valid/ready command stream (address, direction, write data, strobes) into single APB4 transfers driven onto the master side of the APB bus (PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB). It returns read data and error status on a valid/ready response channel. A programmable PREADY timeout aborts transfers to a hung slave. One transfer is outstanding at a time.

## Interface
- ADDR_WIDTH, 32, width of PADDR / req_addr
- DATA_WIDTH, 32, width of PWDATA / PRDATA / req_wdata / rsp_rdata; multiple of 8
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout
- PCLK  in  1  system clock; all state changes on rising edge
- PRESETn  in  1  asynchronous, active-low reset
- req_valid  in  1  command present
- req_ready  out  1  bridge accepts command this cycle
- req_addr  in  ADDR_WIDTH  transfer address
- req_write  in  1  1 write, 0 read
- req_wdata  in  DATA_WIDTH  write data
- req_strb  in  DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
- rsp_slverr  out  1  PSLVERR sampled, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL, PENABLE, PWRITE  out  1  APB master controls
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH; PSTRB  out  DATA_WIDTH/8
- PREADY, PSLVERR  in  1; PRDATA  in  DATA_WIDTH  slave responses

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state IDLE.
- req_ready = (state == IDLE), combinational from state only.
- IDLE: on req_valid && req_ready, register addr/write/wdata/strb into PADDR/PWRITE/PWDATA/PSTRB; -> SETUP. For reads PWDATA and PSTRB are driven 0.
- SETUP: PSEL=1, PENABLE=0; unconditionally -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1. Timeout counter increments each ACCESS cycle with PREADY=0.
  - PREADY=1: capture PRDATA (reads only, else 0) and PSLVERR into rsp regs, rsp_timeout=0; deassert PSEL/PENABLE; -> RESP.
  - PREADY=0 and TIMEOUT_CYCLES!=0 and counter == TIMEOUT_CYCLES-1: abort; rsp_rdata=0, rsp_slverr=1, rsp_timeout=1; deassert PSEL/PENABLE; -> RESP.
  - otherwise remain; PADDR/PWRITE/PWDATA/PSTRB held stable.
- RESP: rsp_valid=1; rsp fields held stable until rsp_valid && rsp_ready; then -> IDLE. APB idle (PSEL=0, PENABLE=0) throughout.
- Counter cleared on entry to SETUP; width clog2(TIMEOUT_CYCLES+1), no wrap.
- PSLVERR sampled only in the cycle PREADY=1 in ACCESS; ignored otherwise.

## Timing
- Reset (async assert, sync release): state IDLE, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0, rsp_valid=0, rsp_rdata=0, rsp_slverr=0, rsp_timeout=0, counter=0; req_ready=1.
- Request accepted at edge N: PSEL=1 after N; PENABLE=1 after N+1; with zero wait states PREADY sampled at N+2; rsp_valid=1 after N+2.
- Each wait state adds one cycle. Timeout with TIMEOUT_CYCLES=T: abort at the T-th ACCESS edge with PREADY=0; rsp_valid after that edge.
- Zero-wait, rsp_ready tied 1: one transfer per 4 cycles (SETUP, ACCESS, RESP, IDLE).
- PREADY=1 at the timeout edge: normal completion wins, rsp_timeout=0.
- rsp_ready stalls: bridge stays in RESP, req_ready=0, APB idle.
- Reset mid-transfer: all outputs to reset values immediately; response discarded.

## Test plan
- Zero-wait write addr=0x10, wdata=0xDEADBEEF, strb=0xF: PSEL 1 cycle before PENABLE, fields stable; rsp_valid 3 cycles after accept, rsp_slverr=0, rsp_rdata=0.
- Read addr=0x20 with slave PREADY low 3 cycles, PRDATA=0xCAFEF00D: PENABLE held 4 cycles, PSTRB=0, PWDATA=0; rsp_rdata=0xCAFEF00D.
- Write with PSLVERR=1 at PREADY: rsp_slverr=1, rsp_timeout=0.
- TIMEOUT_CYCLES=16, PREADY stuck 0: PSEL drops after 16 ACCESS cycles; rsp_slverr=1, rsp_timeout=1, rsp_rdata=0; next request proceeds normally.
- rsp_ready low 5 cycles after response: rsp fields stable, req_ready=0, PSEL=0; on rsp_ready=1, IDLE next cycle, queued req_valid accepted.
- PRESETn asserted during ACCESS: PSEL/PENABLE/rsp_valid 0 without clock edge; after release req_ready=1, fresh transfer completes correctly.
